// File: rtl/rom_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rom_arb_pkg
//  Purpose  : Shared definitions for the ROM read arbiter: FSM state
//             encoding, requester index constants and the default ROM
//             address limit.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package rom_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int unsigned IFETCH = 0;
    localparam int unsigned LOAD   = 1;

    localparam logic [31:0] DEFAULT_ADDR_LIMIT = 32'h0010000;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter2
//  Purpose  : Two-way round-robin pick. A sole requester always wins; when
//             both request, the requester selected by pointer wins.
//  Ports    : req[1:0]   request bits (bit0 = requester 0)
//             pointer    preferred requester when both are active
//             grant[1:0] one-hot winner, 0 when nobody requests
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       pointer,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = pointer ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rom_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rom_read_arbiter
//  Purpose  : Arbitrates instruction-fetch and data-load word reads onto a
//             single combinational ROM with a fixed sampling latency.
//             Misaligned or out-of-range reads complete immediately with an
//             error and never touch the ROM address.
//  Ports    : clk         clock, all state on rising edge
//             rst_n       synchronous active-low reset
//             req[1:0]    read requests (bit0 ifetch, bit1 load)
//             addr[63:0]  {addr1, addr0} byte addresses
//             gnt[1:0]    one-cycle one-hot acceptance
//             rvalid[1:0] one-cycle one-hot response strobe
//             rdata[31:0] response word (held between responses)
//             err         response error flag (held between responses)
//             busy        transaction in progress
//             romAddress  registered ROM byte address
//             romData     ROM word for romAddress
//  Revision : 1.0  initial release
// ============================================================================
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned ROM_LATENCY = 1,
    parameter logic [31:0] ADDR_LIMIT  = DEFAULT_ADDR_LIMIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [63:0] addr,
    output logic [1:0]  gnt,
    output logic [1:0]  rvalid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    output logic [31:0] romAddress,
    input  logic [31:0] romData
);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_pointer;
    logic        r_winner;
    logic [3:0]  r_count;
    logic [31:0] r_rom_address;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [1:0]  w_grant;
    logic        w_granted;
    logic        w_winner;
    logic [31:0] w_sel_addr;
    logic        w_addr_bad;

    rr_arbiter2 u_rr_arbiter2 (
        .req     (req),
        .pointer (r_pointer),
        .grant   (w_grant)
    );

    assign w_granted  = (r_state == ST_IDLE) && (req != 2'b00);
    assign w_winner   = w_grant[LOAD];
    assign w_sel_addr = w_winner ? addr[63:32] : addr[31:0];

    // Last byte of the word is checked in 33 bits so that addresses near the
    // top of the 32-bit space cannot wrap back below the limit.
    assign w_addr_bad = (w_sel_addr[1:0] != 2'b00) ||
                        (({1'b0, w_sel_addr} + 33'd3) >= {1'b0, ADDR_LIMIT});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        gnt          = 2'b00;
        rvalid       = 2'b00;
        busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                // Grant is suppressed during reset so nothing is accepted
                // that the state register is about to discard.
                if (rst_n) begin
                    gnt = w_grant;
                end
                if (w_granted) begin
                    w_state_next = w_addr_bad ? ST_RESP : ST_READ;
                end
            end
            ST_READ: begin
                if (r_count == 4'd0) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                rvalid       = r_winner ? 2'b10 : 2'b01;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pointer     <= 1'b0;
            r_winner      <= 1'b0;
            r_count       <= 4'd0;
            r_rom_address <= 32'd0;
            r_rdata       <= 32'd0;
            r_err         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_granted) begin
                        r_winner  <= w_winner;
                        r_pointer <= ~w_winner;
                        if (w_addr_bad) begin
                            r_rdata <= 32'd0;
                            r_err   <= 1'b1;
                        end else begin
                            r_rom_address <= w_sel_addr;
                            r_count       <= 4'(ROM_LATENCY - 1);
                        end
                    end
                end
                ST_READ: begin
                    if (r_count == 4'd0) begin
                        r_rdata <= romData;
                        r_err   <= 1'b0;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rdata      = r_rdata;
    assign err        = r_err;
    assign romAddress = r_rom_address;

endmodule
`default_nettype wire
